// File: rtl/dma_pkg.sv
// Shared register offsets, CTRL bit positions and FSM encodings for the DMA engine.
// Pure declarations: no latency, no backpressure.
package dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_IE    = 3;
  localparam int CTRL_ABORT = 4;
  localparam int CTRL_FILL  = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_WR   = 3'd4,
    ST_GAP  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/dma_if.sv
// CPU register bus plus SoC master bus of the DMA engine; slave = DMA view, master = SoC view.
// Wires only: no latency; flow control is the req/gnt pair.
interface dma_if;
  logic        i_we;
  logic [15:0] i_addr;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic        o_req;
  logic        i_gnt;
  logic [15:0] o_m_addr;
  logic        o_m_we;
  logic [15:0] o_m_wdata;
  logic [15:0] i_m_rdata;
  logic        o_int;

  modport slave (
    input  i_we, i_addr, i_wdata, i_gnt, i_m_rdata,
    output o_rdata, o_req, o_m_addr, o_m_we, o_m_wdata, o_int
  );

  modport master (
    output i_we, i_addr, i_wdata, i_gnt, i_m_rdata,
    input  o_rdata, o_req, o_m_addr, o_m_we, o_m_wdata, o_int
  );
endinterface

// File: rtl/dma_regs.sv
// DMA register file: decode, SRC/DST/LEN counters, sticky DONE, read mux; FILL bit only with DMA_FILL_EN.
// Latency: writes land on the next edge, reads are combinational; no backpressure (CPU bus never stalls).
module dma_regs
  import dma_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0430
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic        i_idle,
  input  logic        i_busy,
  input  logic        i_step,
  input  logic        i_done_set,
  output logic [15:0] o_rdata,
  output logic [15:0] o_src,
  output logic [15:0] o_dst,
  output logic [15:0] o_len,
  output logic        o_ie,
  output logic        o_done,
  output logic        o_fill,
  output logic        o_start,
  output logic        o_abort
);

  logic [15:0] off;
  logic        hit;
  logic        wr_src, wr_dst, wr_len, wr_ctrl;

  assign off     = i_addr - BASE_ADDR;
  assign hit     = (off < 16'd4);
  assign wr_src  = i_we && hit && (off[1:0] == REG_SRC);
  assign wr_dst  = i_we && hit && (off[1:0] == REG_DST);
  assign wr_len  = i_we && hit && (off[1:0] == REG_LEN);
  assign wr_ctrl = i_we && hit && (off[1:0] == REG_CTRL);

  assign o_start = wr_ctrl && i_wdata[CTRL_START] && i_idle;
  assign o_abort = wr_ctrl && i_wdata[CTRL_ABORT];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_src  <= 16'h0;
      o_dst  <= 16'h0;
      o_len  <= 16'h0;
      o_ie   <= 1'b0;
      o_done <= 1'b0;
    end else begin
      // Address writes are only taken while idle, so they never race the step.
      if (wr_src && i_idle)          o_src <= i_wdata;
      else if (i_step && !o_fill)    o_src <= o_src + 16'd1;
      if (wr_dst && i_idle)          o_dst <= i_wdata;
      else if (i_step)               o_dst <= o_dst + 16'd1;
      if (wr_len && i_idle)          o_len <= i_wdata;
      else if (i_step)               o_len <= o_len - 16'd1;
      if (wr_ctrl)                   o_ie  <= i_wdata[CTRL_IE];
      // Hardware set beats a same-cycle W1C or a fresh launch.
      if (i_done_set)
        o_done <= 1'b1;
      else if ((wr_ctrl && i_wdata[CTRL_DONE]) || (o_start && o_len != 16'h0))
        o_done <= 1'b0;
    end
  end

`ifdef DMA_FILL_EN
  logic fill_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)              fill_q <= 1'b0;
    else if (wr_ctrl && i_idle)  fill_q <= i_wdata[CTRL_FILL];
  end
  assign o_fill = fill_q;
`else
  assign o_fill = 1'b0;
`endif

  always_comb begin
    o_rdata = 16'h0;
    if (hit) begin
      case (off[1:0])
        REG_SRC: o_rdata = o_src;
        REG_DST: o_rdata = o_dst;
        REG_LEN: o_rdata = o_len;
        REG_CTRL: begin
          o_rdata[CTRL_BUSY] = i_busy;
          o_rdata[CTRL_DONE] = o_done;
          o_rdata[CTRL_IE]   = o_ie;
          o_rdata[CTRL_FILL] = o_fill;
        end
        default: o_rdata = 16'h0;
      endcase
    end
  end

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel mem-to-mem DMA: copy 3 cycles/word (fill 1 cycle/word with DMA_FILL_EN), level IRQ on done.
// Backpressure: waits in REQ for i_gnt; releases o_req for one GAP cycle after every BURST words.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0430,
  parameter int          BURST     = 4
) (
  input logic  i_clk,
  input logic  i_reset_n,
  dma_if.slave bus
);

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  state_t      state, state_nxt;
  logic [7:0]  burst_cnt;
  logic [15:0] data_q;
  logic        abort_pend, abort_hit;
  logic [15:0] src, dst, len;
  logic        ie, done, fill, start, abort_wr;
  logic        idle, busy, step, done_set;

  assign idle      = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign step      = (state == ST_WR);
  assign done_set  = (state == ST_DONE) || (idle && start && len == 16'h0);
  assign abort_hit = abort_pend || abort_wr;

  dma_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_we       (bus.i_we),
    .i_addr     (bus.i_addr),
    .i_wdata    (bus.i_wdata),
    .i_idle     (idle),
    .i_busy     (busy),
    .i_step     (step),
    .i_done_set (done_set),
    .o_rdata    (bus.o_rdata),
    .o_src      (src),
    .o_dst      (dst),
    .o_len      (len),
    .o_ie       (ie),
    .o_done     (done),
    .o_fill     (fill),
    .o_start    (start),
    .o_abort    (abort_wr)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && len != 16'h0) state_nxt = ST_REQ;
      ST_REQ: begin
        if (abort_hit)      state_nxt = ST_DONE;
        else if (bus.i_gnt) state_nxt = fill ? ST_WR : ST_RD;
      end
      ST_RD:  state_nxt = ST_CAP;
      ST_CAP: state_nxt = ST_WR;
      ST_WR: begin
        if (len == 16'd1 || abort_hit)  state_nxt = ST_DONE;
        else if (burst_cnt == BURST_LAST) state_nxt = ST_GAP;
        else                            state_nxt = fill ? ST_WR : ST_RD;
      end
      ST_GAP:  state_nxt = ST_REQ;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Master outputs are gated by i_gnt so nothing leaks onto the shared bus ungranted.
  always_comb begin
    bus.o_req     = 1'b0;
    bus.o_m_addr  = 16'h0;
    bus.o_m_we    = 1'b0;
    bus.o_m_wdata = 16'h0;
    case (state)
      ST_REQ, ST_CAP: bus.o_req = 1'b1;
      ST_RD: begin
        bus.o_req = 1'b1;
        if (bus.i_gnt) bus.o_m_addr = src;
      end
      ST_WR: begin
        bus.o_req = 1'b1;
        if (bus.i_gnt) begin
          bus.o_m_addr  = dst;
          bus.o_m_we    = 1'b1;
          bus.o_m_wdata = fill ? src : data_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_int = done & ie;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      burst_cnt  <= 8'h0;
      data_q     <= 16'h0;
      abort_pend <= 1'b0;
    end else begin
      if (state == ST_WR)                            burst_cnt <= burst_cnt + 8'd1;
      else if (state == ST_GAP || state == ST_DONE)  burst_cnt <= 8'h0;
      if (state == ST_CAP) data_q <= bus.i_m_rdata;
      // ABORT is held until the in-flight word finishes its write.
      if (idle || state == ST_DONE) abort_pend <= 1'b0;
      else if (abort_wr)            abort_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a synchronous RAM model and a configurable grant source.
module tb_dma_ctrl;
  import dma_pkg::*;

  localparam logic [15:0] A_SRC  = 16'h0430;
  localparam logic [15:0] A_DST  = 16'h0431;
  localparam logic [15:0] A_LEN  = 16'h0432;
  localparam logic [15:0] A_CTRL = 16'h0433;

  logic i_clk = 1'b0;
  logic i_reset_n;
  always #5 i_clk = ~i_clk;

  dma_if bus();

  dma_ctrl #(.BASE_ADDR(16'h0430), .BURST(4)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  logic gnt_en, gnt_tie;
  assign bus.i_gnt = gnt_en & (gnt_tie | bus.o_req);

  logic [15:0] mem [0:65535];
  logic        ld_en, mem_clr;
  logic [15:0] ld_addr, ld_dat;
  int          wr_cnt = 0;
  int          checks = 0;
  int          passes = 0;

  always @(posedge i_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'h0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_dat;
    end else if (bus.o_m_we) begin
      mem[bus.o_m_addr] <= bus.o_m_wdata;
    end
    if (bus.o_m_we) wr_cnt <= wr_cnt + 1;
    bus.i_m_rdata <= mem[bus.o_m_addr];
  end

  // All tasks are entered just after a falling edge.
  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    bus.i_we = 1'b1; bus.i_addr = a; bus.i_wdata = d;
    @(negedge i_clk);
    bus.i_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [15:0] d);
    bus.i_addr = a;
    #1;
    d = bus.o_rdata;
  endtask

  task automatic mem_ld(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_dat = d;
    @(negedge i_clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    logic [15:0] v;
    cyc = 1;
    forever begin
      cpu_rd(A_CTRL, v);
      if (v[CTRL_DONE]) break;
      if (cyc >= limit) begin
        checks++;
        $display("FAIL done_timeout: DONE still 0 after %0d cycles, expected 1", cyc);
        break;
      end
      @(negedge i_clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    checks++;
    if ({bus.o_req, bus.o_m_we, bus.o_int, bus.o_m_addr, bus.o_m_wdata} !== 35'h0)
      $display("FAIL reset_outputs: got req=%b we=%b int=%b addr=%h wdata=%h, expected all 0",
               bus.o_req, bus.o_m_we, bus.o_int, bus.o_m_addr, bus.o_m_wdata);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      cpu_rd(A_SRC + 16'(i), v);
      checks++;
      if (v !== 16'h0) $display("FAIL reset_reg[%0d]: got %h expected 0000", i, v);
      else passes++;
    end
  endtask

  task automatic test_basic_copy();
    logic [15:0] v;
    int base, cyc;
    mem_ld(16'h0010, 16'hAAAA); mem_ld(16'h0011, 16'hBBBB); mem_ld(16'h0012, 16'hCCCC);
    gnt_en = 1'b1; gnt_tie = 1'b1;
    cpu_wr(A_SRC, 16'h0010); cpu_wr(A_DST, 16'h0100); cpu_wr(A_LEN, 16'h0003);
    base = wr_cnt;
    cpu_wr(A_CTRL, 16'h0009);
    wait_done(100, cyc);
    checks++;
    if ({mem[16'h0100], mem[16'h0101], mem[16'h0102]} !== 48'hAAAA_BBBB_CCCC)
      $display("FAIL copy_data: got %h %h %h expected AAAA BBBB CCCC",
               mem[16'h0100], mem[16'h0101], mem[16'h0102]);
    else passes++;
    checks++;
    if (wr_cnt - base !== 3) $display("FAIL copy_writes: got %0d expected 3", wr_cnt - base);
    else passes++;
    checks++;
    if (bus.o_int !== 1'b1) $display("FAIL copy_int: got %b expected 1", bus.o_int);
    else passes++;
    cpu_rd(A_CTRL, v);
    checks++;
    if (v !== 16'h000C) $display("FAIL copy_ctrl: got %h expected 000C", v);
    else passes++;
    cpu_rd(A_SRC, v);
    checks++;
    if (v !== 16'h0013) $display("FAIL copy_src: got %h expected 0013", v);
    else passes++;
    cpu_rd(A_DST, v);
    checks++;
    if (v !== 16'h0103) $display("FAIL copy_dst: got %h expected 0103", v);
    else passes++;
    cpu_rd(A_LEN, v);
    checks++;
    if (v !== 16'h0000) $display("FAIL copy_len: got %h expected 0000", v);
    else passes++;
    cpu_wr(A_CTRL, 16'h0004);
  endtask

  task automatic test_burst();
    logic [15:0] v;
    int base, cyc, wseen, gapc, nf;
    int falls [2];
    logic prev_req;
    for (int i = 0; i < 10; i++) mem_ld(16'h0030 + 16'(i), 16'h1000 + 16'(i));
    gnt_en = 1'b1; gnt_tie = 1'b0;
    cpu_wr(A_SRC, 16'h0030); cpu_wr(A_DST, 16'h0600); cpu_wr(A_LEN, 16'd10);
    base = wr_cnt;
    cpu_wr(A_CTRL, 16'h0001);
    cyc = 1; wseen = 0; gapc = 0; nf = 0; prev_req = 1'b1;
    falls[0] = -1; falls[1] = -1;
    while (cyc < 200) begin
      cpu_rd(A_CTRL, v);
      if (v[CTRL_DONE]) break;
      if (bus.o_m_we) wseen++;
      if (!bus.o_req && wseen > 0 && wseen < 10) begin
        gapc++;
        if (prev_req && nf < 2) begin falls[nf] = wseen; nf++; end
      end
      prev_req = bus.o_req;
      @(negedge i_clk);
      cyc++;
    end
    checks++;
    if (wseen !== 10 || wr_cnt - base !== 10)
      $display("FAIL burst_writes: got %0d/%0d expected 10", wseen, wr_cnt - base);
    else passes++;
    checks++;
    if (gapc !== 2) $display("FAIL burst_gap_cycles: got %0d expected 2", gapc);
    else passes++;
    checks++;
    if (falls[0] !== 4 || falls[1] !== 8)
      $display("FAIL burst_gap_pos: got %0d,%0d expected 4,8", falls[0], falls[1]);
    else passes++;
    checks++;
    if (cyc !== 37) $display("FAIL burst_cycles: got %0d expected 37", cyc);
    else passes++;
    checks++;
    if (mem[16'h0609] !== 16'h1009) $display("FAIL burst_last_word: got %h expected 1009", mem[16'h0609]);
    else passes++;
    cpu_wr(A_CTRL, 16'h0004);
  endtask

  task automatic test_grant_stall();
    logic [15:0] v;
    int base, cyc, bad;
    mem_ld(16'h0020, 16'hDEAD); mem_ld(16'h0021, 16'hBEEF);
    gnt_en = 1'b0; gnt_tie = 1'b0;
    cpu_wr(A_SRC, 16'h0020); cpu_wr(A_DST, 16'h0200); cpu_wr(A_LEN, 16'h0002);
    base = wr_cnt;
    cpu_wr(A_CTRL, 16'h0001);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cpu_rd(A_CTRL, v);
      if (bus.o_m_we || bus.o_m_addr != 16'h0 || !v[CTRL_BUSY] || !bus.o_req) bad++;
      @(negedge i_clk);
    end
    checks++;
    if (bad !== 0 || wr_cnt - base !== 0)
      $display("FAIL stall_idle_bus: got %0d bad cycles, %0d writes, expected 0 and 0", bad, wr_cnt - base);
    else passes++;
    cpu_wr(A_SRC, 16'h9999);
    gnt_en = 1'b1;
    wait_done(100, cyc);
    checks++;
    if ({mem[16'h0200], mem[16'h0201]} !== 32'hDEAD_BEEF)
      $display("FAIL stall_data: got %h %h expected DEAD BEEF", mem[16'h0200], mem[16'h0201]);
    else passes++;
    cpu_rd(A_SRC, v);
    checks++;
    if (v !== 16'h0022) $display("FAIL busy_write_ignored: got SRC=%h expected 0022", v);
    else passes++;
    cpu_wr(A_CTRL, 16'h0004);
  endtask

  task automatic test_edge_values();
    logic [15:0] v;
    int base, cyc;
    cpu_wr(A_LEN, 16'h0000);
    base = wr_cnt;
    cpu_wr(A_CTRL, 16'h0001);
    cpu_rd(A_CTRL, v);
    checks++;
    if (v !== 16'h0004) $display("FAIL len0_ctrl: got %h expected 0004", v);
    else passes++;
    repeat (3) @(negedge i_clk);
    checks++;
    if (wr_cnt - base !== 0) $display("FAIL len0_no_access: got %0d writes expected 0", wr_cnt - base);
    else passes++;
    cpu_wr(A_CTRL, 16'h0004);
    mem_ld(16'hFFFF, 16'h1234); mem_ld(16'h0000, 16'h5678);
    gnt_en = 1'b1; gnt_tie = 1'b1;
    cpu_wr(A_SRC, 16'hFFFF); cpu_wr(A_DST, 16'h0300); cpu_wr(A_LEN, 16'h0002);
    cpu_wr(A_CTRL, 16'h0001);
    wait_done(100, cyc);
    checks++;
    if ({mem[16'h0300], mem[16'h0301]} !== 32'h1234_5678)
      $display("FAIL wrap_data: got %h %h expected 1234 5678", mem[16'h0300], mem[16'h0301]);
    else passes++;
    cpu_rd(A_SRC, v);
    checks++;
    if (v !== 16'h0001) $display("FAIL wrap_src: got %h expected 0001", v);
    else passes++;
    cpu_wr(A_CTRL, 16'h0004);
  endtask

  task automatic test_abort();
    logic [15:0] v;
    int base, cyc;
    for (int i = 0; i < 8; i++) mem_ld(16'h0040 + 16'(i), 16'h2000 + 16'(i));
    gnt_en = 1'b1; gnt_tie = 1'b1;
    cpu_wr(A_SRC, 16'h0040); cpu_wr(A_DST, 16'h0400); cpu_wr(A_LEN, 16'h0008);
    base = wr_cnt;
    cpu_wr(A_CTRL, 16'h0001);
    repeat (5) @(negedge i_clk);
    cpu_wr(A_CTRL, 16'h0010);
    wait_done(100, cyc);
    repeat (5) @(negedge i_clk);
    checks++;
    if (wr_cnt - base !== 2) $display("FAIL abort_writes: got %0d expected 2", wr_cnt - base);
    else passes++;
    checks++;
    if ({mem[16'h0400], mem[16'h0401], mem[16'h0402]} !== 48'h2000_2001_0000)
      $display("FAIL abort_data: got %h %h %h expected 2000 2001 0000",
               mem[16'h0400], mem[16'h0401], mem[16'h0402]);
    else passes++;
    cpu_rd(A_LEN, v);
    checks++;
    if (v !== 16'h0006) $display("FAIL abort_len: got %h expected 0006", v);
    else passes++;
    cpu_rd(A_SRC, v);
    checks++;
    if (v !== 16'h0042) $display("FAIL abort_src: got %h expected 0042", v);
    else passes++;
    cpu_rd(A_CTRL, v);
    checks++;
    if (v !== 16'h0004) $display("FAIL abort_ctrl: got %h expected 0004", v);
    else passes++;
    cpu_wr(A_CTRL, 16'h0004);
  endtask

  task automatic test_reset_irq();
    logic [15:0] v;
    gnt_en = 1'b1; gnt_tie = 1'b1;
    cpu_wr(A_SRC, 16'h0010); cpu_wr(A_DST, 16'h0700); cpu_wr(A_LEN, 16'h0003);
    cpu_wr(A_CTRL, 16'h0001);
    @(negedge i_clk);
    #1;
    checks++;
    if (bus.o_req !== 1'b1 || bus.o_m_addr !== 16'h0010)
      $display("FAIL rd_phase: got req=%b addr=%h expected 1 0010", bus.o_req, bus.o_m_addr);
    else passes++;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_req, bus.o_m_we, bus.o_int, bus.o_m_addr, bus.o_m_wdata} !== 35'h0)
      $display("FAIL midreset_outputs: got req=%b we=%b int=%b addr=%h wdata=%h expected all 0",
               bus.o_req, bus.o_m_we, bus.o_int, bus.o_m_addr, bus.o_m_wdata);
    else passes++;
    cpu_rd(A_SRC, v);
    checks++;
    if (v !== 16'h0000) $display("FAIL midreset_src: got %h expected 0000", v);
    else passes++;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (4) @(negedge i_clk);
    checks++;
    if (mem[16'h0700] !== 16'h0000) $display("FAIL midreset_no_write: got %h expected 0000", mem[16'h0700]);
    else passes++;
    cpu_wr(A_CTRL, 16'h0009);
    checks++;
    if (bus.o_int !== 1'b1) $display("FAIL irq_set: got %b expected 1", bus.o_int);
    else passes++;
    cpu_wr(A_CTRL, 16'h0008);
    checks++;
    if (bus.o_int !== 1'b1) $display("FAIL irq_hold: got %b expected 1", bus.o_int);
    else passes++;
    cpu_wr(A_CTRL, 16'h000C);
    cpu_rd(A_CTRL, v);
    checks++;
    if (bus.o_int !== 1'b0 || v !== 16'h0008)
      $display("FAIL irq_w1c: got int=%b ctrl=%h expected 0 0008", bus.o_int, v);
    else passes++;
    cpu_wr(A_CTRL, 16'h0004);
  endtask

  task automatic test_fill();
    logic [15:0] v;
`ifdef DMA_FILL_EN
    int n, cnt, first, last;
    gnt_en = 1'b1; gnt_tie = 1'b1;
    cpu_wr(A_SRC, 16'h5A5A); cpu_wr(A_DST, 16'h0500); cpu_wr(A_LEN, 16'h0004);
    cpu_wr(A_CTRL, 16'h0021);
    n = 1; cnt = 0; first = 0; last = 0;
    while (n < 60) begin
      cpu_rd(A_CTRL, v);
      if (v[CTRL_DONE]) break;
      if (bus.o_m_we) begin
        if (cnt == 0) first = n;
        last = n;
        cnt++;
      end
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (cnt !== 4 || last - first !== 3)
      $display("FAIL fill_writes: got %0d writes over %0d cycles expected 4 over 3", cnt, last - first);
    else passes++;
    checks++;
    if ({mem[16'h0500], mem[16'h0501], mem[16'h0502], mem[16'h0503]} !== 64'h5A5A_5A5A_5A5A_5A5A)
      $display("FAIL fill_data: got %h %h %h %h expected 5A5A x4",
               mem[16'h0500], mem[16'h0501], mem[16'h0502], mem[16'h0503]);
    else passes++;
    cpu_rd(A_SRC, v);
    checks++;
    if (v !== 16'h5A5A) $display("FAIL fill_src: got %h expected 5A5A", v);
    else passes++;
    cpu_wr(A_CTRL, 16'h0004);
`else
    cpu_wr(A_CTRL, 16'h0020);
    cpu_rd(A_CTRL, v);
    checks++;
    if (v[CTRL_FILL] !== 1'b0) $display("FAIL fill_absent: got CTRL=%h expected bit5 0", v);
    else passes++;
`endif
  endtask

  initial begin
    i_reset_n   = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_addr  = 16'h0;
    bus.i_wdata = 16'h0;
    gnt_en = 1'b0; gnt_tie = 1'b0;
    ld_en = 1'b0; ld_addr = 16'h0; ld_dat = 16'h0;
    mem_clr = 1'b1;
    repeat (2) @(negedge i_clk);
    mem_clr = 1'b0;
    test_reset();
    i_reset_n = 1'b1;
    @(negedge i_clk);
    test_basic_copy();
    test_burst();
    test_grant_stall();
    test_edge_values();
    test_abort();
    test_reset_irq();
    test_fill();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
